cmu: RTL and testbench

Cache management unit between the CPU data port and the 2-way set-associative data cache (23-bit tag, 5-bit index, 4-word lines). It latches each CPU load/store and looks it up in the cache. On a miss it writes back a dirty LRU victim line and fills the new line one word at a time over a simple request/acknowledge memory bus. It stalls the CPU until the access completes.

---
 rtl/cmu.sv | 183 ++++++++++++++++++
 tb/tb_cmu.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmu.sv
// rtl/cmu.sv - cache management unit: CPU lookup, dirty victim write-back and line fill
// Sequences a 2-way set-associative data cache and a request/acknowledge memory bus.
module cmu #(
  parameter int ADDR_BITS  = 32,
  parameter int TAG_BITS   = 23,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr_rw,
  input  logic                 en_r,
  input  logic                 en_w,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          data_w,
  output logic [31:0]          data_r,
  output logic                 stall,
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_load,
  output logic                 cache_edit,
  output logic                 cache_store,
  output logic                 cache_invalid,
  output logic [2:0]           cache_u_b_h_w,
  output logic [31:0]          cache_din,
  input  logic                 cache_hit,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  input  logic [31:0]          cache_dout,
  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [31:0]          mem_data_o,
  input  logic [31:0]          mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int CNT_BITS = $clog2(LINE_WORDS);
  localparam int OFF_BITS = CNT_BITS + 2;
  localparam int IDX_BITS = ADDR_BITS - TAG_BITS - OFF_BITS;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_BACK_RD,
    S_BACK_WR,
    S_FILL,
    S_WAIT
  } state_t;

  state_t                state;
  logic [CNT_BITS-1:0]   cnt;
  logic [ADDR_BITS-1:0]  req_addr;
  logic [2:0]            req_ubhw;
  logic [31:0]           req_data;
  logic                  req_wr;
  logic [TAG_BITS-1:0]   victim_tag;
  logic [31:0]           wb_data;
  logic                  wb_first;

  logic [IDX_BITS-1:0]   req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [ADDR_BITS-1:0]  victim_line_addr;
  logic [ADDR_BITS-1:0]  fill_line_addr;

  assign req_idx          = req_addr[OFF_BITS +: IDX_BITS];
  assign req_tag          = req_addr[ADDR_BITS-1 -: TAG_BITS];
  assign victim_line_addr = {victim_tag, req_idx, cnt, 2'b00};
  assign fill_line_addr   = {req_tag, req_idx, cnt, 2'b00};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req_addr   <= '0;
      req_ubhw   <= '0;
      req_data   <= '0;
      req_wr     <= 1'b0;
      victim_tag <= '0;
      wb_data    <= '0;
      wb_first   <= 1'b0;
      data_r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en_r | en_w) begin
            req_addr <= addr_rw;
            req_ubhw <= u_b_h_w;
            req_data <= data_w;
            req_wr   <= en_w;
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (cache_hit) begin
            if (!req_wr) data_r <= cache_dout;
            state <= S_IDLE;
          end else if (cache_valid & cache_dirty) begin
            victim_tag <= cache_tag;
            cnt        <= '0;
            state      <= S_BACK_RD;
          end else begin
            cnt   <= '0;
            state <= S_FILL;
          end
        end
        S_BACK_RD: begin
          wb_first <= 1'b1;
          state    <= S_BACK_WR;
        end
        S_BACK_WR: begin
          // Hold the victim word locally so the bus data cannot follow later cache reads.
          if (wb_first) begin
            wb_data  <= cache_dout;
            wb_first <= 1'b0;
          end
          if (mem_ack_i) begin
            cnt   <= cnt + 1'b1;
            state <= (cnt == CNT_LAST) ? S_FILL : S_BACK_RD;
          end
        end
        S_FILL: begin
          if (mem_ack_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= S_WAIT;
          end
        end
        S_WAIT:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cache_addr    = req_addr;
    cache_u_b_h_w = req_ubhw;
    cache_din     = req_data;
    cache_load    = 1'b0;
    cache_edit    = 1'b0;
    cache_store   = 1'b0;
    mem_cs_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    case (state)
      S_IDLE: begin
        cache_addr    = addr_rw;
        cache_u_b_h_w = u_b_h_w;
        cache_din     = data_w;
        // No lookups while reset is held, so LRU state is left alone.
        if (rst & (en_r | en_w)) begin
          cache_edit = en_w;
          cache_load = ~en_w;
        end
      end
      S_BACK_RD: cache_addr = victim_line_addr;
      S_BACK_WR: begin
        cache_addr = victim_line_addr;
        mem_cs_o   = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = victim_line_addr;
        mem_data_o = wb_first ? cache_dout : wb_data;
      end
      S_FILL: begin
        cache_addr = fill_line_addr;
        mem_cs_o   = 1'b1;
        mem_addr_o = fill_line_addr;
        if (mem_ack_i) begin
          cache_store   = 1'b1;
          cache_din     = mem_data_i;
          cache_u_b_h_w = 3'b010;
        end
      end
      default: ;
    endcase
  end

  assign stall = ((state == S_IDLE) & (en_r | en_w)) |
                 ((state != S_IDLE) & ~((state == S_LOOKUP) & cache_hit));

  assign cache_invalid = 1'b0;

endmodule

// File: tb/tb_cmu.sv
// tb/tb_cmu.sv - testbench for cmu with behavioural 2-way cache and delayed-ack memory
module tb_cmu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_rw = '0;
  logic        en_r = 1'b0;
  logic        en_w = 1'b0;
  logic [2:0]  u_b_h_w = '0;
  logic [31:0] data_w = '0;
  logic [31:0] data_r;
  logic        stall;
  logic [31:0] cache_addr;
  logic        cache_load, cache_edit, cache_store, cache_invalid;
  logic [2:0]  cache_u_b_h_w;
  logic [31:0] cache_din;
  logic        cache_hit, cache_valid, cache_dirty;
  logic [22:0] cache_tag;
  logic [31:0] cache_dout;
  logic        mem_cs_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [31:0] mem_data_i = '0;
  logic        mem_ack_i = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cmu dut (
    .clk(clk), .rst(rst), .addr_rw(addr_rw), .en_r(en_r), .en_w(en_w),
    .u_b_h_w(u_b_h_w), .data_w(data_w), .data_r(data_r), .stall(stall),
    .cache_addr(cache_addr), .cache_load(cache_load), .cache_edit(cache_edit),
    .cache_store(cache_store), .cache_invalid(cache_invalid),
    .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din),
    .cache_hit(cache_hit), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
    .cache_tag(cache_tag), .cache_dout(cache_dout),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  txn_t act_q[$];
  int   cyc_q[$];
  int   ack_delay = 2;
  int   stab_err = 0;

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return mem_default(a);
  endfunction

  // Memory: acks after ack_delay cycles of mem_cs_o, checks request stability meanwhile.
  int          wcnt = 0;
  logic [31:0] r_addr, r_data;
  logic        r_we;
  always @(negedge clk) begin
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      wcnt = 0;
    end
    if (mem_cs_o) begin
      if (wcnt == 0) begin
        r_addr = mem_addr_o;
        r_data = mem_data_o;
        r_we   = mem_we_o;
      end else if (r_addr !== mem_addr_o || r_we !== mem_we_o || (r_we && r_data !== mem_data_o)) begin
        stab_err++;
      end
      wcnt++;
      if (wcnt >= ack_delay) begin
        mem_ack_i = 1'b1;
        if (mem_we_o) begin
          mem[mem_addr_o] = mem_data_o;
          act_q.push_back('{we: 1'b1, addr: mem_addr_o, data: mem_data_o});
        end else begin
          mem_data_i = mem_rd(mem_addr_o);
          act_q.push_back('{we: 1'b0, addr: mem_addr_o, data: mem_data_i});
        end
        cyc_q.push_back(wcnt);
      end
    end else begin
      wcnt = 0;
    end
  end

  // Cache: 2 ways x 32 sets x 4 words, registered status/data, victim = c_lru way.
  logic [22:0] c_tag [2][32];
  logic        c_val [2][32];
  logic        c_dty [2][32];
  logic [31:0] c_dat [2][32][4];
  logic        c_lru [32];

  initial begin
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 32; s++) begin
        c_val[w][s] = 1'b0;
        c_dty[w][s] = 1'b0;
        c_tag[w][s] = '0;
      end
    for (int s = 0; s < 32; s++) c_lru[s] = 1'b0;
  end

  function automatic logic [31:0] fmt(input logic [31:0] wd, input logic [1:0] off, input logic [2:0] s);
    logic [31:0] sh;
    sh = wd >> (8 * off);
    if (s[1]) return wd;
    if (s[0]) return s[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    return s[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [1:0] off, input logic [2:0] s);
    if (s[1]) return din;
    if (s[0]) return off[1] ? {din[15:0], old[15:0]} : {old[31:16], din[15:0]};
    case (off)
      2'd0:    return {old[31:8], din[7:0]};
      2'd1:    return {old[31:16], din[7:0], old[7:0]};
      2'd2:    return {old[31:24], din[7:0], old[15:0]};
      default: return {din[7:0], old[23:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    logic [4:0]  idx;
    logic [22:0] tg;
    logic [1:0]  wi;
    int          hw, v;
    logic        hit;
    idx = cache_addr[8:4];
    tg  = cache_addr[31:9];
    wi  = cache_addr[3:2];
    hit = (c_val[0][idx] && c_tag[0][idx] == tg) || (c_val[1][idx] && c_tag[1][idx] == tg);
    hw  = (c_val[0][idx] && c_tag[0][idx] == tg) ? 0 : 1;
    if (cache_load || cache_edit) begin
      cache_hit <= hit;
      if (hit) begin
        c_lru[idx] = (hw == 0);
        if (cache_edit) begin
          c_dat[hw][idx][wi] = merge(c_dat[hw][idx][wi], cache_din, cache_addr[1:0], cache_u_b_h_w);
          c_dty[hw][idx] = 1'b1;
        end else begin
          cache_dout <= fmt(c_dat[hw][idx][wi], cache_addr[1:0], cache_u_b_h_w);
        end
      end else begin
        v = int'(c_lru[idx]);
        cache_valid <= c_val[v][idx];
        cache_dirty <= c_dty[v][idx];
        cache_tag   <= c_tag[v][idx];
      end
    end else if (cache_store) begin
      v = int'(c_lru[idx]);
      if (wi == 2'd0) begin
        c_tag[v][idx] = tg;
        c_val[v][idx] = 1'b0;
        c_dty[v][idx] = 1'b0;
      end
      c_dat[v][idx][wi] = cache_din;
      if (wi == 2'd3) c_val[v][idx] = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++)
        if (c_val[k][idx] && c_tag[k][idx] == tg) cache_dout <= c_dat[k][idx][wi];
    end
  end

  task automatic cpu_access(input bit wr, input logic [31:0] a, input logic [2:0] w,
                            input logic [31:0] d, output int n);
    @(negedge clk);
    addr_rw = a; u_b_h_w = w; data_w = d; en_w = wr; en_r = !wr;
    n = 0;
    #1;
    while (stall && n < 2000) begin
      n++;
      @(negedge clk);
      #1;
    end
    if (stall) begin
      checks++; errors++;
      $display("FAIL access_timeout addr=%h stall still 1 after %0d cycles, expected 0", a, n);
    end
    @(posedge clk);
    #1;
    en_r = 1'b0; en_w = 1'b0;
  endtask

  task automatic push_line(input bit we, input logic [31:0] base);
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{we: we, addr: base + 32'(4 * i), data: mem_rd(base + 32'(4 * i))});
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (stall !== 1'b0)         begin errors++; $display("FAIL rst_stall got %b exp 0", stall); end
    checks++; if (mem_cs_o !== 1'b0)      begin errors++; $display("FAIL rst_mem_cs got %b exp 0", mem_cs_o); end
    checks++; if (mem_we_o !== 1'b0)      begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we_o); end
    checks++; if (cache_load !== 1'b0)    begin errors++; $display("FAIL rst_cache_load got %b exp 0", cache_load); end
    checks++; if (cache_edit !== 1'b0)    begin errors++; $display("FAIL rst_cache_edit got %b exp 0", cache_edit); end
    checks++; if (cache_store !== 1'b0)   begin errors++; $display("FAIL rst_cache_store got %b exp 0", cache_store); end
    checks++; if (cache_invalid !== 1'b0) begin errors++; $display("FAIL rst_cache_invalid got %b exp 0", cache_invalid); end
    checks++; if (data_r !== 32'h0)       begin errors++; $display("FAIL rst_data_r got %h exp 0", data_r); end
    rst = 1'b1;
  endtask

  task automatic test_clean_miss;
    int n;
    txn_t e, a;
    mem[32'h100] = 32'h11; mem[32'h104] = 32'h22; mem[32'h108] = 32'h33; mem[32'h10C] = 32'h44;
    push_line(1'b0, 32'h100);
    cpu_access(1'b0, 32'h104, 3'b010, 32'h0, n);
    checks++; if (n !== 4 + 4 * ack_delay) begin errors++; $display("FAIL clean_stall_cycles got %0d exp %0d", n, 4 + 4 * ack_delay); end
    checks++; if (data_r !== 32'h22) begin errors++; $display("FAIL clean_data_r got %h exp 00000022", data_r); end
    checks++; if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL clean_txn_count got %0d exp %0d", act_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL clean_txn got we=%b %h %h exp we=%b %h %h", a.we, a.addr, a.data, e.we, e.addr, e.data); end
    end
    exp_q.delete(); act_q.delete(); cyc_q.delete();
  endtask

  task automatic test_hit;
    int n;
    cpu_access(1'b0, 32'h108, 3'b010, 32'h0, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL hit_stall_cycles got %0d exp 1", n); end
    checks++; if (data_r !== 32'h33) begin errors++; $display("FAIL hit_data_r got %h exp 00000033", data_r); end
    checks++; if (act_q.size() !== 0) begin errors++; $display("FAIL hit_mem_traffic got %0d txns exp 0", act_q.size()); end
    act_q.delete(); cyc_q.delete();
  endtask

  task automatic test_byte_write;
    int n;
    cpu_access(1'b1, 32'h101, 3'b000, 32'hAB, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL bw_stall_cycles got %0d exp 1", n); end
    cpu_access(1'b0, 32'h100, 3'b010, 32'h0, n);
    checks++; if (data_r !== 32'h0000AB11) begin errors++; $display("FAIL bw_data_r got %h exp 0000ab11", data_r); end
    checks++; if (act_q.size() !== 0) begin errors++; $display("FAIL bw_mem_traffic got %0d txns exp 0", act_q.size()); end
    act_q.delete(); cyc_q.delete();
  endtask

  task automatic test_dirty_miss;
    int n, exp_n;
    txn_t e, a;
    cpu_access(1'b0, 32'h000, 3'b010, 32'h0, n);
    cpu_access(1'b1, 32'h000, 3'b010, 32'hDEAD, n);
    cpu_access(1'b0, 32'h200, 3'b010, 32'h0, n);
    act_q.delete(); cyc_q.delete();
    exp_q.push_back('{we: 1'b1, addr: 32'h000, data: 32'hDEAD});
    for (int i = 1; i < 4; i++)
      exp_q.push_back('{we: 1'b1, addr: 32'(4 * i), data: mem_rd(32'(4 * i))});
    push_line(1'b0, 32'h400);
    exp_n = 4 + 4 * (1 + ack_delay) + 4 * ack_delay;
    cpu_access(1'b0, 32'h400, 3'b010, 32'h0, n);
    checks++; if (n !== exp_n) begin errors++; $display("FAIL dirty_stall_cycles got %0d exp %0d", n, exp_n); end
    checks++; if (data_r !== mem_default(32'h400)) begin errors++; $display("FAIL dirty_data_r got %h exp %h", data_r, mem_default(32'h400)); end
    checks++; if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL dirty_txn_count got %0d exp %0d", act_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL dirty_txn got we=%b %h %h exp we=%b %h %h", a.we, a.addr, a.data, e.we, e.addr, e.data); end
    end
    exp_q.delete(); act_q.delete(); cyc_q.delete();
  endtask

  task automatic test_slow_ack;
    int n, c;
    txn_t e, a;
    ack_delay = 5;
    stab_err = 0;
    push_line(1'b0, 32'h2C0);
    cpu_access(1'b0, 32'h2C4, 3'b010, 32'h0, n);
    checks++; if (n !== 4 + 4 * 5) begin errors++; $display("FAIL slow_stall_cycles got %0d exp %0d", n, 4 + 4 * 5); end
    checks++; if (data_r !== mem_default(32'h2C4)) begin errors++; $display("FAIL slow_data_r got %h exp %h", data_r, mem_default(32'h2C4)); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL slow_stability got %0d unstable cycles exp 0", stab_err); end
    checks++; if (cyc_q.size() !== 4) begin errors++; $display("FAIL slow_req_count got %0d exp 4", cyc_q.size()); end
    while (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      checks++; if (c !== 5) begin errors++; $display("FAIL slow_cs_cycles got %0d exp 5", c); end
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL slow_txn got we=%b %h %h exp we=%b %h %h", a.we, a.addr, a.data, e.we, e.addr, e.data); end
    end
    exp_q.delete(); act_q.delete(); cyc_q.delete();
    ack_delay = 2;
  endtask

  task automatic test_reset_mid_fill;
    int n;
    txn_t e, a;
    act_q.delete(); cyc_q.delete();
    @(negedge clk);
    addr_rw = 32'h1A0; u_b_h_w = 3'b010; en_r = 1'b1;
    n = 0;
    while (act_q.size() < 1 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++; if (act_q.size() < 1) begin errors++; $display("FAIL rmf_first_ack got %0d txns exp 1", act_q.size()); end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (mem_cs_o !== 1'b0)    begin errors++; $display("FAIL rmf_mem_cs got %b exp 0", mem_cs_o); end
    checks++; if (cache_store !== 1'b0) begin errors++; $display("FAIL rmf_cache_store got %b exp 0", cache_store); end
    checks++; if (stall !== 1'b1)       begin errors++; $display("FAIL rmf_stall_held got %b exp 1", stall); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    act_q.delete(); cyc_q.delete();
    push_line(1'b0, 32'h1A0);
    cpu_access(1'b0, 32'h1A0, 3'b010, 32'h0, n);
    checks++; if (n !== 4 + 4 * ack_delay) begin errors++; $display("FAIL rmf_stall_cycles got %0d exp %0d", n, 4 + 4 * ack_delay); end
    checks++; if (data_r !== mem_default(32'h1A0)) begin errors++; $display("FAIL rmf_data_r got %h exp %h", data_r, mem_default(32'h1A0)); end
    checks++; if (act_q.size() !== exp_q.size()) begin errors++; $display("FAIL rmf_txn_count got %0d exp %0d", act_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL rmf_txn got we=%b %h %h exp we=%b %h %h", a.we, a.addr, a.data, e.we, e.addr, e.data); end
    end
    exp_q.delete(); act_q.delete(); cyc_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_miss();
    test_hit();
    test_byte_write();
    test_dirty_miss();
    test_slow_ack();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
